ibuf_ctrl: RTL and testbench
============================

Name: ibuf_ctrl

Overview:
- Write-side sequencer for the CIM input shift buffer (ibuf).
- Accepts input elements from the upstream stream over a valid/ready handshake and drives the ibuf write port.
- Zero-pads short vectors to `fifo_length` entries, then issues a one-cycle compute start to the CIM tile.
- Blocks further input until the tile reports done, so the buffer is never overwritten mid-compute.

Parameters:
- datatype_size, 8, width of one buffer element in bits.
- fifo_length, 5, entries per input vector; must match the ibuf depth; legal range ≥1.
- CNT_W, $clog2(fifo_length+1), width of the fill counter (derived; do not override).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_data_valid  input  1  upstream element valid.
- o_data_ready  output  1  controller can accept an element this cycle.
- i_data  input  datatype_size  upstream element.
- i_last  input  1  qualifies i_data as the final element of a vector; sampled only on handshake.
- o_ibuf_we  output  1  ibuf write enable (registered).
- o_ibuf_data  output  datatype_size  ibuf write data (registered).
- o_cim_start  output  1  one-cycle pulse: buffer full, start compute.
- i_cim_done  input  1  tile finished with the buffer contents; one-cycle pulse or level.
- o_busy  output  1  high in any state other than FILL.
- o_fill_count  output  CNT_W  entries written for the current vector (0..fifo_length).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=FILL, count=0, o_ibuf_we=0, o_ibuf_data=0, o_cim_start=0, o_busy=0, o_fill_count=0. o_data_ready=0 while rst is high.
- Reset mid-operation (any state) discards the partial vector. No start or write is issued on the cycle after reset.
- Handshake:
  - Transfer occurs when i_data_valid & o_data_ready at a rising edge.
  - o_data_ready = (state==FILL) & ~rst, decoded combinationally from state only; never from i_data_valid.
  - i_data and i_last are ignored unless a transfer occurs.
- Write path:
  - On transfer at edge E, o_ibuf_we=1 and o_ibuf_data=i_data in the cycle after E, so latency is 1 cycle.
  - o_ibuf_we=0 in every cycle with no transfer and no pad write.
  - count increments at E.
- States:
  - FILL: accept elements.
    - On a transfer with count+1==fifo_length → START, regardless of i_last.
    - On a transfer with i_last=1 and count+1<fifo_length → PAD.
    - Otherwise stay in FILL.
  - PAD:
    - o_data_ready=0.
    - Each cycle writes zero: o_ibuf_we=1, o_ibuf_data=0, registered as above, and count increments.
    - When the pad write brings count to fifo_length → START.
    - Pad count is exactly fifo_length − (elements received).
  - START:
    - One cycle only; o_cim_start=1 in the following cycle (registered).
    - This is the cycle after the final o_ibuf_we, so ibuf has captured all entries.
    - Next state: WAIT.
  - WAIT:
    - o_data_ready=0; o_fill_count holds fifo_length.
    - On i_cim_done=1: count=0 and state=FILL, so o_data_ready=1 the next cycle.
- i_cim_done handling: ignored in FILL, PAD and START; no latching. A done arriving early is lost, which is a tile protocol violation.
- o_cim_start is never high for two consecutive cycles, and at most once per vector.
- fifo_length=1: every transfer goes FILL→START; PAD is unreachable.
- Counter never exceeds fifo_length; no wrap.
- Back-to-back vectors: the minimum gap from the final accepted element to the next accept is 3 cycles + done latency.

Test Plan:
- Full vector: fifo_length=5; valid held high; data 1,2,3,4,5 with i_last on the 5th → o_ibuf_we high for 5 consecutive cycles with data 1..5; o_cim_start is a single pulse one cycle after the last write; o_data_ready=0 until done; o_fill_count=5 in WAIT.
- Short vector: data 7,9 with i_last on 9 → writes 7,9,0,0,0 with no ready during padding; then exactly one o_cim_start; o_fill_count steps 1..5.
- Backpressure/stall: valid toggled 1,0,1,0,... → write count equals accepted count; no write in stall cycles; o_ibuf_data only changes on writes.
- Done timing: i_cim_done pulsed during PAD → ignored, no FILL return. Then pulse done 10 cycles after start → o_data_ready=1 the next cycle and count=0. Next vector 10..14 is written correctly.
- Reset mid-fill: after 3 accepted elements, assert rst one cycle → all outputs 0 and o_data_ready=0 during rst. A fresh 5-element vector then produces exactly 5 writes and one start.
- fifo_length=1 build: each handshake → one write followed by one start; i_last has no effect.

Source files
------------

// File: rtl/ibuf_ctrl_if.sv
// Stream, ibuf write port and CIM tile handshake bundle for ibuf_ctrl.
// slave is the controller's view; master is the upstream/tile view.
interface ibuf_ctrl_if #(
  parameter int datatype_size = 8,
  parameter int fifo_length   = 5
);
  localparam int CNT_W = $clog2(fifo_length + 1);

  logic                     i_data_valid;
  logic                     o_data_ready;
  logic [datatype_size-1:0] i_data;
  logic                     i_last;
  logic                     o_ibuf_we;
  logic [datatype_size-1:0] o_ibuf_data;
  logic                     o_cim_start;
  logic                     i_cim_done;
  logic                     o_busy;
  logic [CNT_W-1:0]         o_fill_count;

  modport slave (
    input  i_data_valid, i_data, i_last, i_cim_done,
    output o_data_ready, o_ibuf_we, o_ibuf_data, o_cim_start, o_busy, o_fill_count
  );

  modport master (
    output i_data_valid, i_data, i_last, i_cim_done,
    input  o_data_ready, o_ibuf_we, o_ibuf_data, o_cim_start, o_busy, o_fill_count
  );
endinterface

// File: rtl/ibuf_ctrl.sv
// Write-side sequencer for the CIM input shift buffer: fill, zero-pad,
// start the tile, then hold off new input until the tile reports done.
//
// state | meaning
// FILL  | accepting upstream elements
// PAD   | writing zeros until the buffer holds fifo_length entries
// START | last write landed; cim start pulse issued next cycle
// WAIT  | tile computing; input blocked until i_cim_done
module ibuf_ctrl #(
  parameter int datatype_size = 8,
  parameter int fifo_length   = 5
) (
  input  logic        clk,
  input  logic        rst,
  ibuf_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(fifo_length + 1);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(fifo_length);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_PAD   = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     we_q, we_d;
  logic [datatype_size-1:0] data_q, data_d;
  logic                     start_q, start_d;
  logic                     xfer;
  logic [CNT_W-1:0]         count_inc;

  // Ready depends on state only so upstream never sees a valid->ready loop.
  assign bus.o_data_ready = (state_q == S_FILL) & ~rst;
  assign xfer             = bus.i_data_valid & bus.o_data_ready;
  assign count_inc        = count_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    data_d  = data_q;
    start_d = 1'b0;
    case (state_q)
      S_FILL: begin
        if (xfer) begin
          we_d    = 1'b1;
          data_d  = bus.i_data;
          count_d = count_inc;
          if (count_inc == LEN)  state_d = S_START;
          else if (bus.i_last)   state_d = S_PAD;
        end
      end
      S_PAD: begin
        we_d    = 1'b1;
        data_d  = '0;
        count_d = count_inc;
        if (count_inc == LEN) state_d = S_START;
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_cim_done) begin
          count_d = '0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      count_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

  assign bus.o_ibuf_we    = we_q;
  assign bus.o_ibuf_data  = data_q;
  assign bus.o_cim_start  = start_q;
  assign bus.o_busy       = (state_q != S_FILL);
  assign bus.o_fill_count = count_q;
endmodule

// File: tb/tb_ibuf_ctrl.sv
// Directed bench for ibuf_ctrl: a fifo_length=5 instance for the main
// sequences and a fifo_length=1 instance for the degenerate build.
module tb_ibuf_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ibuf_ctrl_if #(.datatype_size(8), .fifo_length(5)) bus5 ();
  ibuf_ctrl_if #(.datatype_size(8), .fifo_length(1)) bus1 ();

  ibuf_ctrl #(.datatype_size(8), .fifo_length(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
  ibuf_ctrl #(.datatype_size(8), .fifo_length(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int writes;
    int starts;
    int acc;
    logic [7:0] last_data;

    bus5.i_data_valid = 1'b0; bus5.i_data = '0; bus5.i_last = 1'b0; bus5.i_cim_done = 1'b0;
    bus1.i_data_valid = 1'b0; bus1.i_data = '0; bus1.i_last = 1'b0; bus1.i_cim_done = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_ready", bus5.o_data_ready, 0);
    chk("rst_we",    bus5.o_ibuf_we,    0);
    chk("rst_data",  bus5.o_ibuf_data,  0);
    chk("rst_start", bus5.o_cim_start,  0);
    chk("rst_busy",  bus5.o_busy,       0);
    chk("rst_count", bus5.o_fill_count, 0);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", bus5.o_data_ready, 1);

    // Full vector 1..5, valid held high
    for (int i = 1; i <= 5; i++) begin
      chk("full_ready_pre", bus5.o_data_ready, 1);
      bus5.i_data_valid = 1'b1;
      bus5.i_data = 8'(i);
      bus5.i_last = (i == 5);
      cyc();
      chk("full_we",    bus5.o_ibuf_we,    1);
      chk("full_data",  bus5.o_ibuf_data,  32'(i));
      chk("full_count", bus5.o_fill_count, 32'(i));
      chk("full_start_early", bus5.o_cim_start, 0);
    end
    chk("full_ready_start", bus5.o_data_ready, 0);
    chk("full_busy",        bus5.o_busy,       1);
    bus5.i_data_valid = 1'b0; bus5.i_last = 1'b0;
    cyc();
    chk("full_start",      bus5.o_cim_start,  1);
    chk("full_we_off",     bus5.o_ibuf_we,    0);
    chk("full_wait_count", bus5.o_fill_count, 5);
    cyc();
    chk("full_start_once", bus5.o_cim_start,  0);
    chk("full_wait_ready", bus5.o_data_ready, 0);
    cyc();
    bus5.i_cim_done = 1'b1;
    cyc();
    bus5.i_cim_done = 1'b0;
    chk("full_done_ready", bus5.o_data_ready, 1);
    chk("full_done_count", bus5.o_fill_count, 0);
    chk("full_done_busy",  bus5.o_busy,       0);

    // Short vector 7,9 -> 7,9,0,0,0 with done pulsed during PAD (ignored)
    bus5.i_data_valid = 1'b1; bus5.i_data = 8'd7; bus5.i_last = 1'b0;
    cyc();
    chk("short_d0", bus5.o_ibuf_data, 8'd7);
    chk("short_c0", bus5.o_fill_count, 1);
    bus5.i_data = 8'd9; bus5.i_last = 1'b1;
    cyc();
    chk("short_d1", bus5.o_ibuf_data, 8'd9);
    chk("short_c1", bus5.o_fill_count, 2);
    bus5.i_data_valid = 1'b0; bus5.i_last = 1'b0; bus5.i_data = 8'hEE;
    bus5.i_cim_done = 1'b1;
    for (int p = 3; p <= 5; p++) begin
      chk("pad_ready", bus5.o_data_ready, 0);
      cyc();
      bus5.i_cim_done = 1'b0;
      chk("pad_we",    bus5.o_ibuf_we,    1);
      chk("pad_data",  bus5.o_ibuf_data,  0);
      chk("pad_count", bus5.o_fill_count, 32'(p));
      chk("pad_start", bus5.o_cim_start,  0);
    end
    cyc();
    chk("short_start", bus5.o_cim_start, 1);
    chk("short_we",    bus5.o_ibuf_we,   0);
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("short_wait_start", bus5.o_cim_start,  0);
      chk("short_wait_ready", bus5.o_data_ready, 0);
      chk("short_wait_count", bus5.o_fill_count, 5);
    end
    bus5.i_cim_done = 1'b1;
    cyc();
    bus5.i_cim_done = 1'b0;
    chk("short_done_ready", bus5.o_data_ready, 1);
    chk("short_done_count", bus5.o_fill_count, 0);

    // Vector 10..14 with valid toggling 1,0,1,0,...
    writes = 0; acc = 0; last_data = 8'd9;
    for (int k = 0; k < 10; k++) begin
      bus5.i_data_valid = (k % 2 == 0);
      bus5.i_data = (k % 2 == 0) ? 8'(10 + k / 2) : 8'hAA;
      bus5.i_last = (k % 2 == 1);
      if (k % 2 == 0) acc++;
      cyc();
      writes += int'(bus5.o_ibuf_we);
      if (k % 2 == 0) begin
        last_data = 8'(10 + k / 2);
        chk("stall_we",    bus5.o_ibuf_we,    1);
        chk("stall_data",  bus5.o_ibuf_data,  last_data);
        chk("stall_count", bus5.o_fill_count, 32'(acc));
      end else begin
        chk("stall_idle_we",   bus5.o_ibuf_we,   0);
        chk("stall_hold_data", bus5.o_ibuf_data, last_data);
      end
    end
    bus5.i_data_valid = 1'b0; bus5.i_last = 1'b0;
    chk("stall_writes", writes, acc);
    chk("stall_start",  bus5.o_cim_start, 1);
    cyc();
    bus5.i_cim_done = 1'b1;
    cyc();
    bus5.i_cim_done = 1'b0;
    chk("stall_done_ready", bus5.o_data_ready, 1);

    // Reset after 3 accepted elements
    for (int i = 0; i < 3; i++) begin
      bus5.i_data_valid = 1'b1; bus5.i_data = 8'(21 + i);
      cyc();
    end
    chk("mid_count3", bus5.o_fill_count, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", bus5.o_data_ready, 0);
    cyc();
    chk("mid_rst_we",    bus5.o_ibuf_we,    0);
    chk("mid_rst_data",  bus5.o_ibuf_data,  0);
    chk("mid_rst_start", bus5.o_cim_start,  0);
    chk("mid_rst_busy",  bus5.o_busy,       0);
    chk("mid_rst_count", bus5.o_fill_count, 0);
    chk("mid_rst_ready2", bus5.o_data_ready, 0);
    rst = 1'b0;
    writes = 0; starts = 0;
    for (int i = 0; i < 5; i++) begin
      bus5.i_data_valid = 1'b1; bus5.i_data = 8'(31 + i);
      cyc();
      writes += int'(bus5.o_ibuf_we);
      starts += int'(bus5.o_cim_start);
      chk("fresh_data", bus5.o_ibuf_data, 8'(31 + i));
    end
    bus5.i_data_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      writes += int'(bus5.o_ibuf_we);
      starts += int'(bus5.o_cim_start);
    end
    chk("fresh_writes", writes, 5);
    chk("fresh_starts", starts, 1);
    bus5.i_cim_done = 1'b1;
    cyc();
    bus5.i_cim_done = 1'b0;

    // fifo_length=1 build: every handshake is one write then one start
    for (int v = 0; v < 2; v++) begin
      chk("n1_ready", bus1.o_data_ready, 1);
      bus1.i_data_valid = 1'b1;
      bus1.i_data = (v == 0) ? 8'h55 : 8'h66;
      bus1.i_last = (v == 1);
      cyc();
      bus1.i_data_valid = 1'b0; bus1.i_last = 1'b0;
      chk("n1_we",    bus1.o_ibuf_we,    1);
      chk("n1_data",  bus1.o_ibuf_data,  (v == 0) ? 8'h55 : 8'h66);
      chk("n1_count", bus1.o_fill_count, 1);
      chk("n1_busy",  bus1.o_busy,       1);
      cyc();
      chk("n1_start", bus1.o_cim_start, 1);
      chk("n1_we_off", bus1.o_ibuf_we,  0);
      bus1.i_cim_done = 1'b1;
      cyc();
      bus1.i_cim_done = 1'b0;
      chk("n1_start_once", bus1.o_cim_start, 0);
      chk("n1_done_ready", bus1.o_data_ready, 1);
      chk("n1_done_count", bus1.o_fill_count, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
